// File: rtl/pid_pkg.sv
// ---------------------------------------------------------------------------
// pid_pkg
// Shared definitions for the PID steering loop blocks: the integrator FSM
// state encoding and the default datapath widths used by the loop terms.
// ---------------------------------------------------------------------------
package pid_pkg;

    // Integrator control states
    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_RUN  = 2'd1,
        I_HOLD = 2'd2
    } i_state_t;

    // Default widths of the loop datapath
    localparam int ERR_W_DEF    = 11;
    localparam int ACC_W_DEF    = 16;
    localparam int OUT_W_DEF    = 10;
    localparam int LEAK_SH_DEF  = 6;
    localparam int LEAK_PER_DEF = 8;

endpackage

// File: rtl/sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// Signed W-bit add/subtract with range checking against a narrower RES_W-bit
// signed result. The caller supplies operands already sign-extended to W bits
// and must leave enough headroom that the W-bit operation itself never wraps.
//
// Ports:
//   a, b  in   W      signed operands (two's complement)
//   sub   in   1      0: a + b, 1: a - b
//   res   out  RES_W  low RES_W bits of the result
//   rail  out  RES_W  the RES_W rail nearest to the true result
//   ovf   out  1      result lies outside the RES_W signed range
// ---------------------------------------------------------------------------
module sat_add #(
    parameter int W     = 18,
    parameter int RES_W = 16
) (
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             sub,
    output logic [RES_W-1:0] res,
    output logic [RES_W-1:0] rail,
    output logic             ovf
);

    // Largest and smallest values representable in RES_W bits, held at W bits
    localparam logic signed [W-1:0] RES_MAX = {{(W - RES_W + 1){1'b0}}, {(RES_W - 1){1'b1}}};
    localparam logic signed [W-1:0] RES_MIN = {{(W - RES_W + 1){1'b1}}, {(RES_W - 1){1'b0}}};

    logic signed [W-1:0] sum;

    always_comb begin
        sum = sub ? ($signed(a) - $signed(b)) : ($signed(a) + $signed(b));
    end

    assign ovf  = (sum > RES_MAX) || (sum < RES_MIN);
    // The sign of the wide result tells which rail was crossed
    assign rail = sum[W-1] ? RES_MIN[RES_W-1:0] : RES_MAX[RES_W-1:0];
    assign res  = sum[RES_W-1:0];

endmodule

// File: rtl/i_term_accum.sv
// ---------------------------------------------------------------------------
// i_term_accum
// Integral-term accumulator for the PID steering loop. Accumulates the
// sign-extended saturated error on each accepted sample, with a freeze or
// clamp policy on overflow, clears on loss of go/moving or a rising edge of
// line_present, and supports a hold. The I term is the top OUT_W bits of the
// accumulator.
//
// Build option: define I_TERM_LEAK_EN to compile in a periodic leak that
// subtracts acc >>> LEAK_SH on every LEAK_PER-th accepted sample. Without it
// the block is a pure integrator and LEAK_SH/LEAK_PER have no effect.
//
// Ports:
//   clk           in   1      clock
//   rst_n         in   1      asynchronous active-low reset
//   err_sat       in   ERR_W  signed saturated error
//   err_vld       in   1      err_sat valid this cycle
//   go, moving    in   1      both high to integrate, either low clears
//   line_present  in   1      rising edge clears the accumulator
//   hold          in   1      freeze accumulator, ignore err_vld
//   sat_mode      in   1      0: freeze on overflow, 1: clamp to rail
//   I_term        out  OUT_W  signed integral term
//   i_vld         out  1      one-cycle pulse, I_term just updated
//   i_sat         out  1      last accepted update overflowed
// ---------------------------------------------------------------------------
module i_term_accum
    import pid_pkg::*;
#(
    parameter int ERR_W    = ERR_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int LEAK_SH  = LEAK_SH_DEF,
    parameter int LEAK_PER = LEAK_PER_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ERR_W-1:0] err_sat,
    input  logic             err_vld,
    input  logic             go,
    input  logic             moving,
    input  logic             line_present,
    input  logic             hold,
    input  logic             sat_mode,
    output logic [OUT_W-1:0] I_term,
    output logic             i_vld,
    output logic             i_sat
);

    // Two guard bits keep acc + err - leak from wrapping before the range check
    localparam int SUM_W = ACC_W + 2;

    // Reject parameter sets the datapath cannot represent
    if (ACC_W <= ERR_W + 1) begin : g_bad_acc_w
        $error("i_term_accum: ACC_W must exceed ERR_W + 1");
    end
    if (OUT_W > ACC_W) begin : g_bad_out_w
        $error("i_term_accum: OUT_W must not exceed ACC_W");
    end
    if (LEAK_PER < 1 || LEAK_SH < 0 || LEAK_SH >= SUM_W) begin : g_bad_leak
        $error("i_term_accum: LEAK_PER must be >= 1 and LEAK_SH within the sum width");
    end

    i_state_t state, state_next;

    logic             line_prev;
    logic [ACC_W-1:0] acc;

    logic run_ok;
    logic line_rise;
    logic clear;
    logic accept;

    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] err_ext;
    logic signed [SUM_W-1:0] addend;

    logic [ACC_W-1:0] sum_res;
    logic [ACC_W-1:0] sum_rail;
    logic             sum_ovf;

    assign run_ok    = go & moving;
    assign line_rise = line_present & ~line_prev;
    assign clear     = ~run_ok | line_rise;
    assign accept    = (state == I_RUN) & ~clear & ~hold & err_vld;

    assign acc_ext = {{2{acc[ACC_W-1]}}, acc};
    assign err_ext = {{(SUM_W - ERR_W){err_sat[ERR_W-1]}}, err_sat};

`ifdef I_TERM_LEAK_EN
    localparam int CNT_W = (LEAK_PER > 1) ? $clog2(LEAK_PER) : 1;

    logic [CNT_W-1:0]        leak_cnt;
    logic                    leak_due;
    logic signed [SUM_W-1:0] leak_term;

    assign leak_due  = (leak_cnt == CNT_W'(LEAK_PER - 1));
    assign leak_term = leak_due ? (acc_ext >>> LEAK_SH) : '0;
    // The leak is folded into the addend; both terms are far inside SUM_W
    assign addend    = err_ext - leak_term;

    // Leak counter counts accepted samples and restarts on any clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leak_cnt <= '0;
        end else if (clear) begin
            leak_cnt <= '0;
        end else if (accept) begin
            leak_cnt <= leak_due ? '0 : leak_cnt + 1'b1;
        end
    end
`else
    assign addend = err_ext;
`endif

    sat_add #(
        .W     (SUM_W),
        .RES_W (ACC_W)
    ) u_sat_add (
        .a    (acc_ext),
        .b    (addend),
        .sub  (1'b0),
        .res  (sum_res),
        .rail (sum_rail),
        .ovf  (sum_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= I_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; losing go/moving overrides every other transition
    always_comb begin
        state_next = state;
        unique case (state)
            I_IDLE:  if (run_ok) state_next = I_RUN;
            I_RUN:   if (hold)   state_next = I_HOLD;
            I_HOLD:  if (!hold)  state_next = I_RUN;
            default: state_next = I_IDLE;
        endcase
        if (!run_ok) begin
            state_next = I_IDLE;
        end
    end

    // Accumulator and status flags. A clear only pulses i_vld when it
    // actually changed the accumulator; frozen overflow samples still pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_prev <= 1'b0;
            acc       <= '0;
            i_sat     <= 1'b0;
            i_vld     <= 1'b0;
        end else begin
            line_prev <= line_present;
            i_vld     <= 1'b0;
            if (clear) begin
                acc   <= '0;
                i_sat <= 1'b0;
                i_vld <= |acc;
            end else if (accept) begin
                i_vld <= 1'b1;
                if (sum_ovf) begin
                    i_sat <= 1'b1;
                    if (sat_mode) begin
                        acc <= sum_rail;
                    end
                end else begin
                    acc   <= sum_res;
                    i_sat <= 1'b0;
                end
            end
        end
    end

    assign I_term = acc[ACC_W-1 -: OUT_W];

endmodule

// File: tb/tb_i_term_accum.sv
// ---------------------------------------------------------------------------
// tb_i_term_accum
// Directed testbench for i_term_accum with LEAK_SH=2 and LEAK_PER=4. Inputs
// are driven 1 ns after each rising edge and outputs are sampled at the same
// point, one edge after the stimulus they respond to.
// ---------------------------------------------------------------------------
module tb_i_term_accum;

    logic        clk;
    logic        rst_n;
    logic [10:0] err_sat;
    logic        err_vld;
    logic        go;
    logic        moving;
    logic        line_present;
    logic        hold;
    logic        sat_mode;
    logic [9:0]  I_term;
    logic        i_vld;
    logic        i_sat;

    int checks = 0;
    int errors = 0;

    i_term_accum #(
        .LEAK_SH  (2),
        .LEAK_PER (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .err_sat      (err_sat),
        .err_vld      (err_vld),
        .go           (go),
        .moving       (moving),
        .line_present (line_present),
        .hold         (hold),
        .sat_mode     (sat_mode),
        .I_term       (I_term),
        .i_vld        (i_vld),
        .i_sat        (i_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse moving low to return to IDLE with acc=0, then re-enter RUN
    task automatic restart();
        err_vld = 1'b0;
        moving  = 1'b0;
        step();
        moving  = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        go           = 1'b1;
        moving       = 1'b1;
        err_vld      = 1'b1;
        err_sat      = 11'sd100;
        line_present = 1'b0;
        hold         = 1'b0;
        sat_mode     = 1'b0;
        step();
        step();
        checks++; if (I_term !== 10'd0) begin errors++; $display("FAIL reset_iterm: got %0h expected 0", I_term); end
        checks++; if (i_vld !== 1'b0) begin errors++; $display("FAIL reset_ivld: got %b expected 0", i_vld); end
        checks++; if (i_sat !== 1'b0) begin errors++; $display("FAIL reset_isat: got %b expected 0", i_sat); end
        err_vld = 1'b0;
        rst_n   = 1'b1;
        step();
        checks++; if (i_vld !== 1'b0) begin errors++; $display("FAIL idle_no_accept: got %b expected 0", i_vld); end
    endtask

    task automatic test_integrate();
        int exp_iterm [10] = '{1, 3, 4, 6, 7, 9, 10, 12, 14, 15};
        for (int k = 0; k < 10; k++) begin
            err_sat = 11'sd100;
            err_vld = 1'b1;
            step();
            checks++; if (i_vld !== 1'b1) begin errors++; $display("FAIL integ_ivld[%0d]: got %b expected 1", k, i_vld); end
            checks++; if (I_term !== 10'(exp_iterm[k])) begin errors++; $display("FAIL integ_iterm[%0d]: got %0d expected %0d", k, I_term, exp_iterm[k]); end
        end
        checks++; if (i_sat !== 1'b0) begin errors++; $display("FAIL integ_isat: got %b expected 0", i_sat); end
        err_vld = 1'b0;
        step();
        checks++; if (i_vld !== 1'b0) begin errors++; $display("FAIL integ_ivld_idle: got %b expected 0", i_vld); end
        checks++; if (I_term !== 10'd15) begin errors++; $display("FAIL integ_iterm_steady: got %0d expected 15", I_term); end
    endtask

    task automatic test_line_clear();
        line_present = 1'b1;
        err_sat      = 11'sd100;
        err_vld      = 1'b1;
        step();
        checks++; if (I_term !== 10'd0) begin errors++; $display("FAIL line_clear_iterm: got %0d expected 0", I_term); end
        checks++; if (i_vld !== 1'b1) begin errors++; $display("FAIL line_clear_ivld: got %b expected 1", i_vld); end
        err_sat = 11'sd640;
        step();
        checks++; if (I_term !== 10'd10) begin errors++; $display("FAIL line_high_no_reclear: got %0d expected 10", I_term); end
        checks++; if (i_vld !== 1'b1) begin errors++; $display("FAIL line_high_ivld: got %b expected 1", i_vld); end
        err_vld      = 1'b0;
        line_present = 1'b0;
        step();
    endtask

    task automatic test_hold();
        hold    = 1'b1;
        err_sat = 11'sd640;
        err_vld = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (I_term !== 10'd10) begin errors++; $display("FAIL hold_iterm[%0d]: got %0d expected 10", k, I_term); end
            checks++; if (i_vld !== 1'b0) begin errors++; $display("FAIL hold_ivld[%0d]: got %b expected 0", k, i_vld); end
        end
        hold    = 1'b0;
        err_vld = 1'b0;
        step();
        err_vld = 1'b1;
        step();
        checks++; if (I_term !== 10'd20) begin errors++; $display("FAIL hold_resume_iterm: got %0d expected 20", I_term); end
        checks++; if (i_vld !== 1'b1) begin errors++; $display("FAIL hold_resume_ivld: got %b expected 1", i_vld); end
        err_vld = 1'b0;
        step();
    endtask

    task automatic test_moving_clear();
        moving = 1'b0;
        step();
        checks++; if (I_term !== 10'd0) begin errors++; $display("FAIL moving_clear_iterm: got %0d expected 0", I_term); end
        checks++; if (i_vld !== 1'b1) begin errors++; $display("FAIL moving_clear_ivld: got %b expected 1", i_vld); end
        moving = 1'b1;
        step();
        checks++; if (i_vld !== 1'b0) begin errors++; $display("FAIL moving_reassert_ivld: got %b expected 0", i_vld); end
        err_sat = 11'sd640;
        err_vld = 1'b1;
        step();
        checks++; if (I_term !== 10'd10) begin errors++; $display("FAIL moving_from_zero: got %0d expected 10", I_term); end
        err_vld = 1'b0;
        step();
    endtask

    task automatic test_saturate();
        restart();
        // 32 x 1023 + 16 = 32752 = 0x7FF0
        err_vld = 1'b1;
        err_sat = 11'sd1023;
        for (int k = 0; k < 32; k++) step();
        err_sat = 11'sd16;
        step();
        sat_mode = 1'b0;
        err_sat  = 11'sd1023;
        step();
        checks++; if (i_sat !== 1'b1) begin errors++; $display("FAIL freeze_isat: got %b expected 1", i_sat); end
        checks++; if (i_vld !== 1'b1) begin errors++; $display("FAIL freeze_ivld: got %b expected 1", i_vld); end
        checks++; if (I_term !== 10'h1FF) begin errors++; $display("FAIL freeze_iterm: got %0h expected 1ff", I_term); end
        err_vld = 1'b0;
        step();
        checks++; if (i_sat !== 1'b1) begin errors++; $display("FAIL isat_sticky_idle: got %b expected 1", i_sat); end
        // 32752 - 49 = 32703 -> 510; proves acc was frozen at 0x7FF0
        err_vld = 1'b1;
        err_sat = -11'sd49;
        step();
        checks++; if (I_term !== 10'h1FE) begin errors++; $display("FAIL freeze_probe_iterm: got %0h expected 1fe", I_term); end
        checks++; if (i_sat !== 1'b0) begin errors++; $display("FAIL freeze_probe_isat: got %b expected 0", i_sat); end
        err_sat = 11'sd49;
        step();
        sat_mode = 1'b1;
        err_sat  = 11'sd1023;
        step();
        checks++; if (i_sat !== 1'b1) begin errors++; $display("FAIL clamp_isat: got %b expected 1", i_sat); end
        checks++; if (I_term !== 10'h1FF) begin errors++; $display("FAIL clamp_iterm: got %0h expected 1ff", I_term); end
        // 32767 - 49 = 32718 -> 511; proves acc was clamped to 0x7FFF
        err_sat = -11'sd49;
        step();
        checks++; if (I_term !== 10'h1FF) begin errors++; $display("FAIL clamp_probe_iterm: got %0h expected 1ff", I_term); end
        // Negative rail: 32 x -1024 = -32768 exactly, then -1 overflows
        restart();
        err_vld = 1'b1;
        err_sat = -11'sd1024;
        for (int k = 0; k < 32; k++) step();
        checks++; if (i_sat !== 1'b0) begin errors++; $display("FAIL neg_edge_isat: got %b expected 0", i_sat); end
        checks++; if (I_term !== 10'h200) begin errors++; $display("FAIL neg_edge_iterm: got %0h expected 200", I_term); end
        err_sat = -11'sd1;
        step();
        checks++; if (i_sat !== 1'b1) begin errors++; $display("FAIL neg_clamp_isat: got %b expected 1", i_sat); end
        checks++; if (I_term !== 10'h200) begin errors++; $display("FAIL neg_clamp_iterm: got %0h expected 200", I_term); end
        err_vld  = 1'b0;
        sat_mode = 1'b0;
        step();
    endtask

    task automatic test_leak();
        logic [9:0] exp_final;
        restart();
        err_vld = 1'b1;
        err_sat = 11'sd400;
        step();
        checks++; if (I_term !== 10'd6) begin errors++; $display("FAIL leak_start_iterm: got %0d expected 6", I_term); end
        err_sat = 11'sd0;
        for (int k = 0; k < 3; k++) step();
`ifdef I_TERM_LEAK_EN
        // Fourth sample after clear leaks 400 >>> 2 = 100 -> 300 -> I_term 4
        exp_final = 10'd4;
`else
        exp_final = 10'd6;
`endif
        checks++; if (I_term !== exp_final) begin errors++; $display("FAIL leak_final_iterm: got %0d expected %0d", I_term, exp_final); end
        checks++; if (i_vld !== 1'b1) begin errors++; $display("FAIL leak_ivld: got %b expected 1", i_vld); end
        err_vld = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_integrate();
        test_line_clear();
        test_hold();
        test_moving_clear();
        test_saturate();
        test_leak();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
